// File: rtl/sparc_window_regfile.sv
// -----------------------------------------------------------------------------
// sparc_window_regfile
//   Windowed SPARC V8 integer register file. Logical r0-r31 are translated to
//   physical storage through the current window pointer (CWP). SAVE/RESTORE
//   rotate the window and raise overflow/underflow traps against the WIM.
//
// Ports:
//   clk            rising-edge clock
//   reset_n        asynchronous active-low reset
//   we_onehot[31:0] one-hot write select (bit k writes logical rk)
//   wdata          write data
//   ra_addr/rb_addr logical read addresses (combinational read ports)
//   ra_data/rb_data read data
//   save/restore   CWP decrement / increment requests
//   wim            window invalid mask (bit w set = window w invalid)
//   cwp            current window pointer
//   trap_overflow  one-cycle pulse: SAVE blocked by WIM
//   trap_underflow one-cycle pulse: RESTORE blocked by WIM
//   we_error       one-cycle pulse: more than one write-enable bit set
//
// Optional feature (macro SPARC_REGFILE_BYPASS_EN): a read whose physical
// address matches a valid same-cycle write returns wdata combinationally.
// -----------------------------------------------------------------------------
module sparc_window_regfile #(
    parameter int NWINDOWS = 8,
    parameter int WIDTH    = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [31:0]         we_onehot,
    input  logic [WIDTH-1:0]    wdata,
    input  logic [4:0]          ra_addr,
    input  logic [4:0]          rb_addr,
    output logic [WIDTH-1:0]    ra_data,
    output logic [WIDTH-1:0]    rb_data,
    input  logic                save,
    input  logic                restore,
    input  logic [NWINDOWS-1:0] wim,
    output logic [4:0]          cwp,
    output logic                trap_overflow,
    output logic                trap_underflow,
    output logic                we_error
);

    localparam int NPHYS = 8 + 16 * NWINDOWS;
    localparam int PW    = $clog2(NPHYS);

    // Logical register -> physical index for window w. Outs of window w live
    // in the ins block of window w-1, which gives the overlapping windows.
    function automatic logic [PW-1:0] xlate(input logic [4:0] r, input logic [4:0] w);
        int ri;
        int wi;
        int blk;
        int p;
        ri  = int'(r);
        wi  = int'(w);
        blk = 0;
        p   = 0;
        if (ri < 8) begin
            p = ri;
        end else if (ri < 16) begin
            blk = (wi == 0) ? (NWINDOWS - 1) : (wi - 1);
            p   = 8 + 16 * blk + (ri - 8);
        end else if (ri < 24) begin
            p = 8 + 16 * wi + 8 + (ri - 16);
        end else begin
            p = 8 + 16 * wi + (ri - 24);
        end
        return p[PW-1:0];
    endfunction

    logic [WIDTH-1:0] regs_q [NPHYS];
    logic [4:0]       cwp_q, cwp_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             err_q, err_d;

    logic             wr_single_s;
    logic             wr_multi_s;
    logic             wr_valid_s;
    logic [4:0]       wr_idx_s;
    logic [PW-1:0]    wr_phys_s;
    logic [PW-1:0]    ra_phys_s;
    logic [PW-1:0]    rb_phys_s;
    logic [4:0]       next_dn_s;
    logic [4:0]       next_up_s;
    logic             wim_dn_s;
    logic             wim_up_s;

    // Classify the write select: single bit, multiple bits, and the encoded index.
    always_comb begin
        wr_single_s = (we_onehot != 32'd0) && ((we_onehot & (we_onehot - 32'd1)) == 32'd0);
        wr_multi_s  = (we_onehot != 32'd0) && !wr_single_s;
        wr_valid_s  = wr_single_s && !we_onehot[0];
        wr_idx_s    = 5'd0;
        for (int k = 0; k < 32; k++) begin
            wr_idx_s = wr_idx_s | (we_onehot[k] ? 5'(k) : 5'd0);
        end
    end

    assign wr_phys_s = xlate(wr_idx_s, cwp_q);
    assign ra_phys_s = xlate(ra_addr, cwp_q);
    assign rb_phys_s = xlate(rb_addr, cwp_q);

    // Candidate window pointers (mod NWINDOWS) and their WIM bits.
    always_comb begin
        next_dn_s = (cwp_q == 5'd0) ? 5'(NWINDOWS - 1) : (cwp_q - 5'd1);
        next_up_s = (cwp_q == 5'(NWINDOWS - 1)) ? 5'd0 : (cwp_q + 5'd1);
        wim_dn_s  = 1'b0;
        wim_up_s  = 1'b0;
        for (int i = 0; i < NWINDOWS; i++) begin
            wim_dn_s = wim_dn_s | (wim[i] & (next_dn_s == 5'(i)));
            wim_up_s = wim_up_s | (wim[i] & (next_up_s == 5'(i)));
        end
    end

    // Next-state for CWP, trap pulses and the write-error pulse.
    always_comb begin
        cwp_d = cwp_q;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        err_d = wr_multi_s;
        case ({save, restore})
            2'b10: begin
                if (wim_dn_s) begin
                    ovf_d = 1'b1;
                end else begin
                    cwp_d = next_dn_s;
                end
            end
            2'b01: begin
                if (wim_up_s) begin
                    unf_d = 1'b1;
                end else begin
                    cwp_d = next_up_s;
                end
            end
            default: begin
                cwp_d = cwp_q;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cwp_q <= 5'd0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            cwp_q <= cwp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
            err_q <= err_d;
        end
    end

    // Register array; the write address is translated with the pre-edge CWP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NPHYS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_valid_s) begin
            regs_q[wr_phys_s] <= wdata;
        end
    end

    // Read port A.
    always_comb begin
        if (ra_addr == 5'd0) begin
            ra_data = '0;
`ifdef SPARC_REGFILE_BYPASS_EN
        end else if (wr_valid_s && (wr_phys_s == ra_phys_s)) begin
            ra_data = wdata;
`endif
        end else begin
            ra_data = regs_q[ra_phys_s];
        end
    end

    // Read port B.
    always_comb begin
        if (rb_addr == 5'd0) begin
            rb_data = '0;
`ifdef SPARC_REGFILE_BYPASS_EN
        end else if (wr_valid_s && (wr_phys_s == rb_phys_s)) begin
            rb_data = wdata;
`endif
        end else begin
            rb_data = regs_q[rb_phys_s];
        end
    end

    assign cwp            = cwp_q;
    assign trap_overflow  = ovf_q;
    assign trap_underflow = unf_q;
    assign we_error       = err_q;

endmodule

// File: doc/sparc_window_regfile.md
Name: sparc_window_regfile

Overview:
- Windowed SPARC V8 integer register file for the datapath.
- Consumes the 32-bit one-hot write-enable produced by the 5-to-32 register decoder. Translates logical r0–r31 to physical storage through the current window pointer (CWP).
- Executes SAVE/RESTORE window rotation and flags window overflow/underflow against the WIM.
- Two combinational read ports feed the ALU operand muxes.

Parameters:
- NWINDOWS, 8, number of register windows; legal range 2..32.
- WIDTH, 32, register data width.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- we_onehot  input  32  one-hot write select from the decoder; bit k writes logical rk.
- wdata  input  WIDTH  write data.
- ra_addr  input  5  logical read address, port A.
- rb_addr  input  5  logical read address, port B.
- ra_data  output  WIDTH  port A read data.
- rb_data  output  WIDTH  port B read data.
- save  input  1  request CWP decrement.
- restore  input  1  request CWP increment.
- wim  input  NWINDOWS  window invalid mask; bit w set = window w invalid.
- cwp  output  5  current window pointer.
- trap_overflow  output  1  one-cycle pulse: SAVE blocked by WIM.
- trap_underflow  output  1  one-cycle pulse: RESTORE blocked by WIM.
- we_error  output  1  one-cycle pulse: we_onehot had more than one bit set.

Behaviour:
- Physical storage is 8 + 16*NWINDOWS registers.
  - Globals r1–r7 map to phys 1–7.
  - phys 0 is unused.
- Window block w has base B(w) = 8 + 16*w:
  - ins r24–r31 map to B(w)+0..7.
  - locals r16–r23 map to B(w)+8..15.
  - outs r8–r15 map to B((w-1) mod NWINDOWS)+0..7, so outs of w alias ins of w-1.
- Reads are combinational.
  - r0 always reads 0.
  - Address translation uses the present cwp.
- Writes commit on the rising clk edge.
  - Exactly one bit set in we_onehot: write logical rk, translated with the pre-edge cwp.
  - Bit 0 set alone: no write, no error.
  - All zero: no write.
  - Two or more bits set: no write; we_error pulses high for the following cycle.
- A written value is visible on the read ports in the cycle after the edge (see the optional feature for same-cycle behaviour).
- save=1, restore=0 at a clock edge:
  - next = (cwp - 1) mod NWINDOWS.
  - If wim[next]=1: cwp is unchanged and trap_overflow=1 for one cycle.
  - Otherwise cwp <= next.
- restore=1, save=0 at a clock edge:
  - next = (cwp + 1) mod NWINDOWS.
  - If wim[next]=1: cwp is unchanged and trap_underflow=1 for one cycle.
  - Otherwise cwp <= next.
- save=1 and restore=1 together: no CWP change and no trap.
- Wrap-around:
  - cwp=0 with SAVE gives NWINDOWS-1.
  - cwp=NWINDOWS-1 with RESTORE gives 0.
- Write combined with SAVE/RESTORE in the same cycle: the write uses the old cwp.
- Trap pulses and we_error deassert the next cycle unless re-triggered.
- Reset (asynchronous, any time, including mid-sequence):
  - All physical registers <= 0.
  - cwp <= 0.
  - trap_overflow, trap_underflow and we_error <= 0.
  - Read outputs then reflect the zeroed array.

Optional Feature:
- Macro: SPARC_REGFILE_BYPASS_EN.
- Defined:
  - A read port whose translated physical address equals the physical address of a valid single-bit write in the same cycle returns wdata combinationally.
  - r0 still reads 0.
- Undefined:
  - The read returns the stored (old) value until the next cycle.

Test Plan:
- Reset, then read r0–r31 -> all 0; cwp=0; all pulse outputs 0.
- we_onehot=32'h0001_0000 (r16), wdata=32'hDEAD_BEEF at cwp=0 -> next cycle ra_addr=16 reads DEAD_BEEF. SAVE to cwp=7 -> r16 reads 0.
- cwp=0, write r8=32'h1234_5678, then SAVE (wim=0) -> cwp=7; r24 reads 1234_5678. RESTORE -> cwp=0; r8 reads 1234_5678.
- wim=8'h80, cwp=0, save=1 -> cwp stays 0 and trap_overflow pulses one cycle. wim=8'h02, restore=1 -> cwp stays 0 and trap_underflow pulses.
- we_onehot=32'h0000_0006 with wdata=32'hFFFF_FFFF -> we_error pulses; r1 and r2 remain 0. we_onehot=32'h1, wdata=5 -> r0 reads 0, no error.
- With SPARC_REGFILE_BYPASS_EN: write r3=32'hA5A5 with ra_addr=3 in the same cycle -> ra_data=A5A5 that cycle. Without the macro -> ra_data=0 that cycle, A5A5 the next. Assert reset_n mid-SAVE -> cwp=0 immediately.
